// File: rtl/iq_settle_detect.sv
// Convergence monitor for the IQ compensator weights: tracks per-window peak-to-peak
// spans of Wr/Wj and freezes the compensator once they stay quiet long enough.
module iq_settle_detect #(
    parameter int unsigned W_WIDTH        = 13,
    parameter int unsigned WIN_LEN        = 64,
    parameter int unsigned STABLE_WINDOWS = 4,
    parameter int unsigned MAX_WINDOWS    = 32
) (
    input  logic                      clk,
    input  logic                      RESETn,
    input  logic                      enable,
    input  logic                      sample_valid,
    input  logic signed [W_WIDTH-1:0] Wr,
    input  logic signed [W_WIDTH-1:0] Wj,
    input  logic        [7:0]         thresh,
    output logic                      freeze_iqcomp,
    output logic                      settled,
    output logic                      timeout,
    output logic        [1:0]         state,
    output logic        [7:0]         win_count
);

    localparam int unsigned CW = $clog2(WIN_LEN);
    localparam int unsigned SW = W_WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StTrack   = 2'b01,
        StSettled = 2'b10,
        StTimeout = 2'b11
    } state_e;

    state_e                      state_q, state_d;
    logic signed [W_WIDTH-1:0]   min_r_q, min_r_d, max_r_q, max_r_d;
    logic signed [W_WIDTH-1:0]   min_j_q, min_j_d, max_j_q, max_j_d;
    logic        [CW-1:0]        samp_cnt_q, samp_cnt_d;
    logic        [3:0]           stable_q, stable_d;
    logic        [7:0]           win_q, win_d;
    logic                        settled_q, timeout_q, freeze_q;

    logic                        first_smp, last_smp, quiet;
    logic signed [W_WIDTH-1:0]   nxt_min_r, nxt_max_r, nxt_min_j, nxt_max_j;
    logic        [SW-1:0]        span_r, span_j;

    assign first_smp = (samp_cnt_q == '0);
    assign last_smp  = (samp_cnt_q == CW'(WIN_LEN - 1));

    // Extremes including the sample on the bus, so the closing sample counts toward its window
    assign nxt_min_r = (first_smp || (Wr < min_r_q)) ? Wr : min_r_q;
    assign nxt_max_r = (first_smp || (Wr > max_r_q)) ? Wr : max_r_q;
    assign nxt_min_j = (first_smp || (Wj < min_j_q)) ? Wj : min_j_q;
    assign nxt_max_j = (first_smp || (Wj > max_j_q)) ? Wj : max_j_q;

    // One extra bit keeps max - min non-negative over the full signed range
    assign span_r = {nxt_max_r[W_WIDTH-1], nxt_max_r} - {nxt_min_r[W_WIDTH-1], nxt_min_r};
    assign span_j = {nxt_max_j[W_WIDTH-1], nxt_max_j} - {nxt_min_j[W_WIDTH-1], nxt_min_j};
    assign quiet  = (32'(span_r) <= 32'(thresh)) && (32'(span_j) <= 32'(thresh));

    always_comb begin
        state_d    = state_q;
        min_r_d    = min_r_q;
        max_r_d    = max_r_q;
        min_j_d    = min_j_q;
        max_j_d    = max_j_q;
        samp_cnt_d = samp_cnt_q;
        stable_d   = stable_q;
        win_d      = win_q;

        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StTrack;
            end
            StTrack: begin
                if (sample_valid) begin
                    min_r_d    = nxt_min_r;
                    max_r_d    = nxt_max_r;
                    min_j_d    = nxt_min_j;
                    max_j_d    = nxt_max_j;
                    samp_cnt_d = samp_cnt_q + CW'(1);
                    if (last_smp) begin
                        stable_d = quiet ? stable_q + 4'd1 : 4'd0;
                        win_d    = (win_q == 8'hff) ? 8'hff : win_q + 8'd1;
                        if (stable_d == 4'(STABLE_WINDOWS)) begin
                            state_d = StSettled;
                        end else if (win_d == 8'(MAX_WINDOWS)) begin
                            state_d = StTimeout;
                        end
                    end
                end
            end
            default: ;
        endcase

        // Abort from any state wins over a coincident sample and discards the partial window
        if (!enable) begin
            state_d    = StIdle;
            min_r_d    = '0;
            max_r_d    = '0;
            min_j_d    = '0;
            max_j_d    = '0;
            samp_cnt_d = '0;
            stable_d   = '0;
            win_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= StIdle;
            min_r_q    <= '0;
            max_r_q    <= '0;
            min_j_q    <= '0;
            max_j_q    <= '0;
            samp_cnt_q <= '0;
            stable_q   <= '0;
            win_q      <= '0;
            settled_q  <= 1'b0;
            timeout_q  <= 1'b0;
            freeze_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_r_q    <= min_r_d;
            max_r_q    <= max_r_d;
            min_j_q    <= min_j_d;
            max_j_q    <= max_j_d;
            samp_cnt_q <= samp_cnt_d;
            stable_q   <= stable_d;
            win_q      <= win_d;
            settled_q  <= (state_d == StSettled);
            timeout_q  <= (state_d == StTimeout);
            freeze_q   <= (state_d == StSettled) || (state_d == StTimeout);
        end
    end

    assign state         = state_q;
    assign settled       = settled_q;
    assign timeout       = timeout_q;
    assign freeze_iqcomp = freeze_q;
    assign win_count     = win_q;

endmodule

// File: tb/tb_iq_settle_detect.sv
// Scoreboard bench for iq_settle_detect: a window-buffer model predicts each decision
// and the per-sample state, which are compared against the DUT after every clock.
module tb_iq_settle_detect;

    localparam int W  = 13;
    localparam int WL = 64;
    localparam int SN = 4;
    localparam int MW = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                enable = 1'b0;
    logic                sample_valid = 1'b0;
    logic signed [W-1:0] wr = '0;
    logic signed [W-1:0] wj = '0;
    logic        [7:0]   thresh = 8'd8;
    logic                freeze, settled, timeout;
    logic        [1:0]   state;
    logic        [7:0]   win_count;

    iq_settle_detect #(
        .W_WIDTH(W), .WIN_LEN(WL), .STABLE_WINDOWS(SN), .MAX_WINDOWS(MW)
    ) dut (
        .clk          (clk),
        .RESETn       (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .Wr           (wr),
        .Wj           (wj),
        .thresh       (thresh),
        .freeze_iqcomp(freeze),
        .settled      (settled),
        .timeout      (timeout),
        .state        (state),
        .win_count    (win_count)
    );

    always #5 clk = ~clk;

    typedef struct {int st; int wc;} exp_t;
    exp_t exp_q[$];

    int   n_checks = 0;
    int   n_pass = 0;
    int   m_state, m_stable, m_win;
    int   m_wr[$];
    int   m_wj[$];
    logic freeze_prev = 1'b0;

    task automatic check_eq(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_stable = 0;
        m_win    = 0;
        m_wr.delete();
        m_wj.delete();
    endtask

    // Buffer a full window, then judge it from the stored samples
    task automatic model_sample(input int r, input int j);
        int lo_r, hi_r, lo_j, hi_j;
        bit q;
        exp_t e;
        if (m_state != 1) return;
        m_wr.push_back(r);
        m_wj.push_back(j);
        if (m_wr.size() == WL) begin
            lo_r = m_wr[0]; hi_r = m_wr[0]; lo_j = m_wj[0]; hi_j = m_wj[0];
            foreach (m_wr[i]) begin
                if (m_wr[i] < lo_r) lo_r = m_wr[i];
                if (m_wr[i] > hi_r) hi_r = m_wr[i];
                if (m_wj[i] < lo_j) lo_j = m_wj[i];
                if (m_wj[i] > hi_j) hi_j = m_wj[i];
            end
            m_wr.delete();
            m_wj.delete();
            q        = (hi_r - lo_r <= int'(thresh)) && (hi_j - lo_j <= int'(thresh));
            m_stable = q ? m_stable + 1 : 0;
            m_win    = (m_win == 255) ? 255 : m_win + 1;
            if (m_stable == SN) m_state = 2;
            else if (m_win == MW) m_state = 3;
            if (m_state >= 2) begin
                e.st = m_state;
                e.wc = m_win;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        check_eq({tag, "_state"}, int'(state), m_state);
        check_eq({tag, "_freeze"}, int'(freeze), int'(m_state >= 2));
        check_eq({tag, "_settled"}, int'(settled), int'(m_state == 2));
        check_eq({tag, "_timeout"}, int'(timeout), int'(m_state == 3));
        check_eq({tag, "_win_count"}, int'(win_count), m_win);
        if (freeze && !freeze_prev) begin
            check_eq("pending_decisions", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("dec_state", int'(state), e.st);
                check_eq("dec_settled", int'(settled), int'(e.st == 2));
                check_eq("dec_timeout", int'(timeout), int'(e.st == 3));
                check_eq("dec_win_count", int'(win_count), e.wc);
            end
        end
        freeze_prev = freeze;
    endtask

    // All stimulus tasks start and end at a falling edge
    task automatic drive_sample(input int r, input int j, input int gap);
        repeat (gap) @(negedge clk);
        sample_valid = 1'b1;
        wr = W'(r);
        wj = W'(j);
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        model_sample(r, j);
        check_outputs("sample");
    endtask

    task automatic do_enable();
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (m_state == 0) m_state = 1;
        check_outputs("enable");
    endtask

    task automatic do_abort(input bit with_valid);
        enable       = 1'b0;
        sample_valid = with_valid;
        wr           = W'(-7);
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        model_reset();
        check_outputs("abort");
        check_eq("leftover_decisions", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("idle");

        // Constant weights settle after four windows
        thresh = 8'd8;
        do_enable();
        for (int k = 0; k < 4 * WL; k++) drive_sample(100, -50, 0);
        do_abort(1'b0);

        // Alternating 0/20 never goes quiet and times out
        do_enable();
        for (int k = 0; k < MW * WL; k++) drive_sample((k % 2 != 0) ? 20 : 0, 0, 0);
        do_abort(1'b0);

        // Span exactly at threshold counts as quiet
        do_enable();
        for (int k = 0; k < 4 * WL; k++)
            drive_sample((k % 2 != 0) ? 108 : 100, (k % 2 != 0) ? -42 : -50, 0);
        do_abort(1'b0);

        // One over-threshold sample in window 3 restarts the run
        do_enable();
        for (int k = 0; k < 7 * WL; k++)
            drive_sample((k == 2 * WL + 5) ? 109 : ((k % 2 != 0) ? 108 : 100), 7, 0);
        do_abort(1'b0);

        // Full-scale swings with random gaps; windows must track valid count only
        thresh = 8'd255;
        do_enable();
        for (int k = 0; k < 5 * WL; k++)
            drive_sample((k % 2 != 0) ? 4095 : -4096, 0, int'($urandom_range(0, 5)));
        do_abort(1'b1);

        // Abort mid-window with a coincident sample, then a fresh run
        thresh = 8'd8;
        do_enable();
        for (int k = 0; k < 100; k++) drive_sample(100, -50, 0);
        do_abort(1'b1);
        do_enable();
        for (int k = 0; k < 4 * WL; k++) drive_sample(-300, 250, 0);

        // Asynchronous reset between edges while settled
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_state = 1;
        check_outputs("post_reset");
        check_eq("leftover_decisions", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
